// File: rtl/product_accum_pkg.sv
// Shared constants for the product accumulator: FSM encoding, default widths
// and the saturation bounds of a signed accumulator.
package product_accum_pkg;
   localparam int ACC_W_DEF = 40;
   localparam int LEN_W_DEF = 8;
   localparam int SAT_W_MAX = 128;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   // Bounds are built at the widest supported size; callers cast down to w bits.
   function automatic logic [SAT_W_MAX-1:0] sat_max(input int w);
      logic [SAT_W_MAX-1:0] v;
      v = '0;
      for (int i = 0; i < SAT_W_MAX; i++)
         if (i < w - 1) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [SAT_W_MAX-1:0] sat_min(input int w);
      logic [SAT_W_MAX-1:0] v;
      v = '0;
      v[w-1] = 1'b1;
      return v;
   endfunction
endpackage

// File: rtl/sat_adder.sv
// Signed saturating adder: sums at W+1 bits and clamps on overflow.
module sat_adder
   import product_accum_pkg::*;
#(
   parameter int W = ACC_W_DEF
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         sat
);
   localparam logic [W-1:0] SAT_MAX = W'(sat_max(W));
   localparam logic [W-1:0] SAT_MIN = W'(sat_min(W));

   logic [W:0] wide;

   always_comb begin
      wide = {a[W-1], a} + {b[W-1], b};
      sum  = wide[W-1:0];
      sat  = 1'b0;
      // Top two bits disagree only when the true result left the W-bit range.
      if (wide[W:W-1] == 2'b01) begin
         sum = SAT_MAX;
         sat = 1'b1;
      end else if (wide[W:W-1] == 2'b10) begin
         sum = SAT_MIN;
         sat = 1'b1;
      end
   end
endmodule

// File: rtl/product_accumulator.sv
// Accumulates a frame of signed 32-bit products into a saturating ACC_W-bit
// sum and holds it for a valid/ready handoff.
module product_accumulator
   import product_accum_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             gated_clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic [31:0]      prod,
   input  logic             prod_valid,
   output logic             prod_ready,
   input  logic [LEN_W-1:0] frame_len,
   output logic [ACC_W-1:0] acc_out,
   output logic             acc_valid,
   input  logic             acc_ready,
   output logic             overflow,
   output logic             busy
);
   logic [1:0]       state;
   logic [ACC_W-1:0] acc;
   logic [LEN_W:0]   cnt;
   logic [LEN_W:0]   len_q;
   logic             ovf_q;

   logic [ACC_W-1:0] prod_ext;
   logic [ACC_W-1:0] sum;
   logic             sat;
   logic [LEN_W:0]   len_ext;
   logic [LEN_W:0]   cnt_inc;

   assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
   // A zero length field encodes a full 2^LEN_W frame.
   assign len_ext  = (frame_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, frame_len};
   assign cnt_inc  = cnt + 1'b1;

   sat_adder #(.W(ACC_W)) u_add (
      .a   (acc),
      .b   (prod_ext),
      .sum (sum),
      .sat (sat)
   );

   always_ff @(posedge gated_clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         acc   <= '0;
         cnt   <= '0;
         len_q <= '0;
         ovf_q <= 1'b0;
      end else if (clear) begin
         state <= ST_IDLE;
         acc   <= '0;
         cnt   <= '0;
         ovf_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (prod_valid) begin
               len_q <= len_ext;
               acc   <= prod_ext;
               cnt   <= {{LEN_W{1'b0}}, 1'b1};
               ovf_q <= 1'b0;
               state <= (len_ext == {{LEN_W{1'b0}}, 1'b1}) ? ST_HOLD : ST_ACCUM;
            end
            ST_ACCUM: if (prod_valid) begin
               acc <= sum;
               cnt <= cnt_inc;
               if (sat) ovf_q <= 1'b1;
               if (cnt_inc == len_q) state <= ST_HOLD;
            end
            ST_HOLD: if (acc_ready) begin
               state <= ST_IDLE;
               ovf_q <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign prod_ready = (state != ST_HOLD);
   assign acc_valid  = (state == ST_HOLD);
   assign busy       = (state != ST_IDLE);
   assign acc_out    = acc;
   assign overflow   = ovf_q;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator (ACC_W=33, LEN_W=8) with hand-computed results.
module tb_product_accumulator;
   localparam int ACC_W = 33;
   localparam int LEN_W = 8;

   logic             gated_clk;
   logic             rst_n;
   logic             clear;
   logic [31:0]      prod;
   logic             prod_valid;
   logic             prod_ready;
   logic [LEN_W-1:0] frame_len;
   logic [ACC_W-1:0] acc_out;
   logic             acc_valid;
   logic             acc_ready;
   logic             overflow;
   logic             busy;

   int n_chk = 0;
   int n_err = 0;

   product_accumulator #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .gated_clk  (gated_clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .prod       (prod),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .frame_len  (frame_len),
      .acc_out    (acc_out),
      .acc_valid  (acc_valid),
      .acc_ready  (acc_ready),
      .overflow   (overflow),
      .busy       (busy)
   );

   initial gated_clk = 1'b0;
   always #5 gated_clk = ~gated_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one product from a negedge; returns at the negedge after it is accepted.
   task automatic push(input logic [31:0] p);
      int n;
      n = 0;
      prod = p;
      prod_valid = 1'b1;
      while (!prod_ready && n < 50) begin
         @(negedge gated_clk);
         n++;
      end
      if (!prod_ready) check("push_timeout", 64'(n), 64'd0);
      @(negedge gated_clk);
      prod_valid = 1'b0;
   endtask

   // Handshake cycle must show the bubble; the following cycle is back in IDLE.
   task automatic handoff(input string tag);
      acc_ready = 1'b1;
      check({tag, "_bubble"}, 64'(prod_ready), 64'd0);
      @(negedge gated_clk);
      acc_ready = 1'b0;
      check({tag, "_vld_clr"}, 64'(acc_valid), 64'd0);
      check({tag, "_ovf_clr"}, 64'(overflow), 64'd0);
      check({tag, "_rdy_back"}, 64'(prod_ready), 64'd1);
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; prod = '0; prod_valid = 1'b0;
      frame_len = '0; acc_ready = 1'b0;
      @(negedge gated_clk);
      check("rst_acc", 64'(acc_out), 64'd0);
      check("rst_vld", 64'(acc_valid), 64'd0);
      check("rst_ovf", 64'(overflow), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_rdy", 64'(prod_ready), 64'd1);
      rst_n = 1'b1;
      @(negedge gated_clk);

      // len=4: 100-30+7+1 = 78; frame_len change mid-frame must be ignored
      frame_len = 8'd4;
      push(32'd100);
      frame_len = 8'd1;
      check("f4_busy", 64'(busy), 64'd1);
      push(-32'sd30);
      push(32'd7);
      check("f4_not_early", 64'(acc_valid), 64'd0);
      push(32'd1);
      check("f4_vld", 64'(acc_valid), 64'd1);
      check("f4_acc", 64'(acc_out), 64'd78);
      check("f4_ovf", 64'(overflow), 64'd0);
      handoff("f4");

      // len=1, -5 sign-extended to 33 bits
      frame_len = 8'd1;
      push(-32'sd5);
      check("f1_vld", 64'(acc_valid), 64'd1);
      check("f1_acc", 64'(acc_out), 64'h1_FFFF_FFFB);
      @(negedge gated_clk);
      check("f1_rdy_hold", 64'(prod_ready), 64'd0);
      handoff("f1");

      // positive saturation: 3 * 0x7FFFFFFF clamps to 2^32-1
      frame_len = 8'd3;
      repeat (3) push(32'h7FFF_FFFF);
      check("psat_acc", 64'(acc_out), 64'h0_FFFF_FFFF);
      check("psat_ovf", 64'(overflow), 64'd1);
      handoff("psat");

      // negative saturation: 3 * -2^31 clamps to -2^32
      frame_len = 8'd3;
      repeat (3) push(32'h8000_0000);
      check("nsat_acc", 64'(acc_out), 64'h1_0000_0000);
      check("nsat_ovf", 64'(overflow), 64'd1);
      handoff("nsat");

      // accumulation continues from the clamp: (2^32-1) + (-1)
      frame_len = 8'd4;
      repeat (3) push(32'h7FFF_FFFF);
      check("cont_ovf_mid", 64'(overflow), 64'd1);
      check("cont_vld_mid", 64'(acc_valid), 64'd0);
      push(32'hFFFF_FFFF);
      check("cont_acc", 64'(acc_out), 64'h0_FFFF_FFFE);
      check("cont_ovf", 64'(overflow), 64'd1);
      handoff("cont");

      // len=0 means 256 products, with random valid gaps
      frame_len = 8'd0;
      for (int i = 0; i < 256; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge gated_clk);
         if (i == 100) check("l0_idle_acc", 64'(acc_out), 64'd100);
         push(32'd1);
         if (i == 254) check("l0_not_early", 64'(acc_valid), 64'd0);
      end
      check("l0_vld", 64'(acc_valid), 64'd1);
      check("l0_acc", 64'(acc_out), 64'd256);
      handoff("l0");

      // stall in HOLD, then clear aborts the held frame
      frame_len = 8'd3;
      repeat (3) push(32'h7FFF_FFFF);
      for (int i = 0; i < 4; i++) begin
         @(negedge gated_clk);
         check("stall_acc", 64'(acc_out), 64'h0_FFFF_FFFF);
         check("stall_vld", 64'(acc_valid), 64'd1);
         check("stall_ovf", 64'(overflow), 64'd1);
         check("stall_rdy", 64'(prod_ready), 64'd0);
      end
      clear = 1'b1;
      acc_ready = 1'b1;
      @(negedge gated_clk);
      clear = 1'b0;
      acc_ready = 1'b0;
      check("clr_vld", 64'(acc_valid), 64'd0);
      check("clr_busy", 64'(busy), 64'd0);
      check("clr_acc", 64'(acc_out), 64'd0);
      check("clr_ovf", 64'(overflow), 64'd0);

      // clear wins over an accepted product mid-frame
      frame_len = 8'd4;
      push(32'd9);
      prod = 32'd5; prod_valid = 1'b1; clear = 1'b1;
      @(negedge gated_clk);
      prod_valid = 1'b0; clear = 1'b0;
      check("clrp_busy", 64'(busy), 64'd0);
      check("clrp_acc", 64'(acc_out), 64'd0);

      // async reset mid-frame, then a fresh len=2 frame
      frame_len = 8'd4;
      push(32'd10);
      push(32'd20);
      #1 rst_n = 1'b0;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_acc", 64'(acc_out), 64'd0);
      check("arst_rdy", 64'(prod_ready), 64'd1);
      @(negedge gated_clk);
      rst_n = 1'b1;
      @(negedge gated_clk);
      check("arst_no_out", 64'(acc_valid), 64'd0);
      frame_len = 8'd2;
      push(32'd3);
      push(32'd4);
      check("post_vld", 64'(acc_valid), 64'd1);
      check("post_acc", 64'(acc_out), 64'd7);
      handoff("post");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
